// File: rtl/serial_subtractor_pkg.sv
// subtractor_pkg: shared FSM state type and encoding width for the serial subtractor.
package subtractor_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor_fa.sv
// FA: single-bit full-adder cell; port names match the existing team cell.
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock through a single full adder.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]  cnt;
    logic           c, s, co;

    // Subtraction as a + ~b + ~bin: the subtrahend bit is inverted into the adder.
    FA u_fa (.A(a_sh[0]), .B(~b_sh[0]), .Cin(c), .S(s), .Cout(co));

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    c     <= ~bin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    r_sh <= {s, r_sh[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= co;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= {s, r_sh[WIDTH-1:1]};
                        bout  <= ~co;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic [3:0] a = 0, b = 0;
    logic       bin = 0;
    logic       busy, done, bout;
    logic [3:0] diff;
    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;

    // Issue one operation from the negedge phase; returns negedges until done (99 on timeout).
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                          output int cycles);
        a = ta; b = tb; bin = tbin; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        cycles = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) cycles = 99;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy, done, diff, bout} !== 7'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%0d bout=%b, want all 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b want 0", busy);
        end
    endtask

    task automatic test_vec(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                            input logic [3:0] ed, input logic eb, input int ecyc);
        int cyc;
        run_op(ta, tb, tbin, cyc);
        checks++;
        if (cyc !== ecyc) begin
            errors++;
            $display("FAIL latency %0d-%0d-%0d: cycles=%0d want %0d", ta, tb, tbin, cyc, ecyc);
        end
        checks++;
        if ({diff, bout} !== {ed, eb}) begin
            errors++;
            $display("FAIL result %0d-%0d-%0d: diff=%0d bout=%b want diff=%0d bout=%b",
                     ta, tb, tbin, diff, bout, ed, eb);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_done: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        int busy_low = 0;
        logic [3:0] seen = 0;
        a = 9; b = 3; bin = 0; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        if (!busy) busy_low++;
        a = 1; b = 1; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 12; i++) begin
            if (dones == 0 && !busy) busy_low++;
            if (done) begin
                dones++;
                seen = diff;
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_start_dones: got %0d want 1", dones);
        end
        checks++;
        if (seen !== 4'd6) begin
            errors++;
            $display("FAIL ignore_start_diff: got %0d want 6", seen);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL ignore_start_busy: busy low %0d cycles want 0", busy_low);
        end
    endtask

    task automatic test_reset_mid_op;
        int dones = 0;
        int cyc;
        a = 12; b = 5; bin = 0; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b diff=%0d bout=%b want all 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: dones=%0d want 0", dones);
        end
        run_op(12, 5, 0, cyc);
        checks++;
        if ({diff, bout} !== {4'd7, 1'b0} || cyc !== 5) begin
            errors++;
            $display("FAIL after_reset_op: diff=%0d bout=%b cycles=%0d want 7 0 5", diff, bout, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int last = -1;
        int pulses = 0;
        int bad_gap = 0;
        int bad_diff = 0;
        a = 5; b = 2; bin = 0; start = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0 && i - last != 6) bad_gap++;
                last = i;
                pulses++;
            end
            if (pulses > 0 && diff !== 4'd3) bad_diff++;
        end
        start = 0;
        checks++;
        if (pulses < 4) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d want >=4", pulses);
        end
        checks++;
        if (bad_gap !== 0) begin
            errors++;
            $display("FAIL b2b_period: %0d gaps differ from 6", bad_gap);
        end
        checks++;
        if (bad_diff !== 0) begin
            errors++;
            $display("FAIL b2b_diff_stable: %0d samples differ from 3", bad_diff);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vec(9, 3, 0, 4'd6, 1'b0, 5);
        test_vec(3, 9, 0, 4'd10, 1'b1, 5);
        test_vec(0, 0, 1, 4'd15, 1'b1, 5);
        test_vec(15, 15, 0, 4'd0, 1'b0, 5);
        test_vec(7, 0, 1, 4'd6, 1'b0, 5);
        test_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
